// File: rtl/seg_scan_controller.sv
// -----------------------------------------------------------------------------
// seg_scan_controller
//   Drives four multiplexed 7-segment digits through one shared segment
//   decoder. It keeps a double-buffered set of four 5-bit display codes
//   (0-15 hex, 16 dash, 17 blank) and lights one digit at a time. It also
//   provides leading-zero blanking, per-digit blink, and tear-free frame
//   updates: a new code set becomes visible only at a frame boundary.
//
// Parameters
//   DIGIT_TICKS   clk cycles each digit stays lit (>=2)
//   BLINK_FRAMES  full frames per blink half-period (>=1)
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   load_valid_i   a new 4-digit code set is offered
//   load_ready_o   the pending buffer is free to accept load_data_i
//   load_data_i    digit n code = load_data_i[5n+4:5n], n=0 is the rightmost digit
//   blank_lz_i     1 = blank leading zeros
//   blink_mask_i   bit n = digit n blinks
//   digit_code_o   code sent to the segment decoder (registered)
//   an_o           anode enables, active-low, one-hot-zero (registered)
//   frame_start_o  1-cycle pulse when a pending set is committed
// -----------------------------------------------------------------------------
module seg_scan_controller #(
  parameter int DIGIT_TICKS  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_valid_i,
  output logic        load_ready_o,
  input  logic [19:0] load_data_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  blink_mask_i,
  output logic [4:0]  digit_code_o,
  output logic [3:0]  an_o,
  output logic        frame_start_o
);

  localparam int             TW         = $clog2(DIGIT_TICKS);
  localparam int             FW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [TW-1:0]  TICK_LAST  = TW'(DIGIT_TICKS - 1);
  localparam logic [FW-1:0]  FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [4:0]     CODE_BLANK = 5'd17;

  logic [TW-1:0]     tick_q, tick_d;
  logic [1:0]        idx_q, idx_d;
  logic [FW-1:0]     frame_cnt_q, frame_cnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [3:0][4:0]   active_q, active_d;
  logic [3:0][4:0]   pending_q, pending_d;
  logic              pending_flag_q, pending_flag_d;
  logic              load_ready_q, load_ready_d;
  logic [3:0]        an_q, an_d;
  logic [4:0]        digit_code_q, digit_code_d;
  logic              frame_start_q, frame_start_d;

  logic              terminal, boundary, transfer;
  logic [3:0][4:0]   shown;
  logic              seen_nz;

  assign terminal = (tick_q == TICK_LAST);
  assign boundary = terminal && (idx_q == 2'd3);
  assign transfer = load_valid_i && load_ready_q;

  // Per-digit display code. The scan goes from the most significant digit
  // down, so seen_nz records whether any digit from 3 down to n is non-zero.
  // Dash and blank codes count as non-zero. Digit 0 is never lz-blanked.
  always_comb begin
    shown   = '0;
    seen_nz = 1'b0;
    for (int n = 3; n >= 0; n--) begin
      seen_nz = seen_nz | (active_q[n] != 5'd0);
      if (blink_phase_q && blink_mask_i[n])
        shown[n] = CODE_BLANK;
      else if (blank_lz_i && (n != 0) && !seen_nz)
        shown[n] = CODE_BLANK;
      else
        shown[n] = active_q[n];
    end
  end

  always_comb begin
    tick_d         = tick_q;
    idx_d          = idx_q;
    frame_cnt_d    = frame_cnt_q;
    blink_phase_d  = blink_phase_q;
    active_d       = active_q;
    pending_d      = pending_q;
    pending_flag_d = pending_flag_q;
    load_ready_d   = load_ready_q;
    frame_start_d  = 1'b0;
    // The outputs follow idx one cycle late, so the anode and its code
    // always change together.
    an_d           = ~(4'b0001 << idx_q);
    digit_code_d   = shown[idx_q];

    if (terminal) begin
      tick_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      tick_d = tick_q + 1'b1;
    end

    if (boundary) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    // load_ready is the inverse of pending_flag, so a transfer and a commit
    // never happen in the same cycle. Data taken on a boundary cycle
    // therefore waits for the next boundary.
    if (transfer) begin
      pending_d      = load_data_i;
      pending_flag_d = 1'b1;
      load_ready_d   = 1'b0;
    end else if (boundary && pending_flag_q) begin
      active_d       = pending_q;
      pending_flag_d = 1'b0;
      load_ready_d   = 1'b1;
      frame_start_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tick_q         <= '0;
      idx_q          <= '0;
      frame_cnt_q    <= '0;
      blink_phase_q  <= 1'b0;
      active_q       <= {4{CODE_BLANK}};
      pending_q      <= {4{CODE_BLANK}};
      pending_flag_q <= 1'b0;
      load_ready_q   <= 1'b1;
      an_q           <= 4'b1111;
      digit_code_q   <= CODE_BLANK;
      frame_start_q  <= 1'b0;
    end else begin
      tick_q         <= tick_d;
      idx_q          <= idx_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_phase_q  <= blink_phase_d;
      active_q       <= active_d;
      pending_q      <= pending_d;
      pending_flag_q <= pending_flag_d;
      load_ready_q   <= load_ready_d;
      an_q           <= an_d;
      digit_code_q   <= digit_code_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign load_ready_o  = load_ready_q;
  assign an_o          = an_q;
  assign digit_code_o  = digit_code_q;
  assign frame_start_o = frame_start_q;

endmodule
